// File: rtl/seg_display_scanner_if.sv
// Signal bundle between a display source (CPU debug outputs) and the
// seven-segment scanner: shadowed value/mask inputs plus scan outputs.
interface seg_display_scanner_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] Data;
  logic                    Load;
  logic [NUM_DIGITS-1:0]   DigitEn;
  logic                    BlankLZ;
  logic [NUM_DIGITS-1:0]   DpMask;
  logic [6:0]              out7;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   en_out;
  logic [IDX_W-1:0]        DigitIdx;

  modport master (
    output Data, Load, DigitEn, BlankLZ, DpMask,
    input  out7, dp_out, en_out, DigitIdx
  );

  modport slave (
    input  Data, Load, DigitEn, BlankLZ, DpMask,
    output out7, dp_out, en_out, DigitIdx
  );
endinterface

// File: rtl/seg_display_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with refresh prescaler,
// load-strobed shadow registers, digit enables, leading-zero blanking and DPs.
module seg_display_scanner #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input logic                  Clk,
  input logic                  Reset,
  seg_display_scanner_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0]        presc;
  logic                    tick;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        next_idx;
  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   zero_from;

  logic [3:0]              nibble_p0;
  logic                    digit_on_p0;
  logic                    blank_p0;
  logic [6:0]              seg_p0;
  logic                    dp_p0;
  logic [NUM_DIGITS-1:0]   en_p0;

  logic [6:0]              seg_p1;
  logic                    dp_p1;
  logic [NUM_DIGITS-1:0]   en_p1;

  assign tick     = (presc == CNT_W'(REFRESH_DIV - 1));
  assign next_idx = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= next_idx;
    end else begin
      presc <= presc + CNT_W'(1);
    end
  end

  // The digit lit on a tick edge uses the pre-edge shadow, so a Load on the
  // same edge only shows up from the following tick.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
    end else if (bus.Load) begin
      shadow_data <= bus.Data;
      shadow_dp   <= bus.DpMask;
    end
  end

  // zero_from[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
  always_comb begin
    logic acc;
    acc       = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc          = acc & (shadow_data[4*i +: 4] == 4'd0);
      zero_from[i] = acc;
    end
  end

  // ---- stage p0: decode the digit that becomes lit at the next tick ----
  always_comb begin
    int sel;
    sel         = int'(next_idx);
    nibble_p0   = shadow_data[4*sel +: 4];
    digit_on_p0 = bus.DigitEn[sel];
    blank_p0    = bus.BlankLZ && (next_idx != '0) && zero_from[sel];
    seg_p0      = 7'h7F;
    dp_p0       = 1'b1;
    en_p0       = '1;
    if (digit_on_p0) begin
      en_p0  = ~(NUM_DIGITS'(1) << next_idx);
      seg_p0 = blank_p0 ? 7'h7F : hex_to_seg(nibble_p0);
      dp_p0  = ~shadow_dp[sel];
    end
  end

  // ---- stage p1: registered pin drivers, reloaded only on tick ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      seg_p1 <= 7'h7F;
      dp_p1  <= 1'b1;
      en_p1  <= '1;
    end else if (tick) begin
      seg_p1 <= seg_p0;
      dp_p1  <= dp_p0;
      en_p1  <= en_p0;
    end
  end

  assign bus.out7     = seg_p1;
  assign bus.dp_out   = dp_p1;
  assign bus.en_out   = en_p1;
  assign bus.DigitIdx = idx;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner: 8 digits at REFRESH_DIV=4 plus a
// REFRESH_DIV=1 instance sharing clock and reset.
module tb_seg_display_scanner;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seg_display_scanner_if #(.NUM_DIGITS(8)) bus4 ();
  seg_display_scanner_if #(.NUM_DIGITS(8)) bus1 ();

  seg_display_scanner #(.NUM_DIGITS(8), .REFRESH_DIV(4)) dut4 (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus4)
  );

  seg_display_scanner #(.NUM_DIGITS(8), .REFRESH_DIV(1)) dut1 (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait n edges (landing on a tick), then check the lit slot.
  task automatic step_slot(input string tag, input int n, input logic [2:0] idx,
                           input logic [7:0] en, input logic [6:0] seg, input logic dp);
    wait_edges(n);
    check({tag, "_idx"}, bus4.DigitIdx, idx);
    check({tag, "_en"},  bus4.en_out,   en);
    check({tag, "_seg"}, bus4.out7,     seg);
    check({tag, "_dp"},  bus4.dp_out,   dp);
  endtask

  // Capture on a non-tick edge right after a tick.
  task automatic load_word(input logic [31:0] d, input logic [7:0] dp);
    bus4.Data   = d;
    bus4.DpMask = dp;
    bus4.Load   = 1'b1;
    wait_edges(1);
    bus4.Load   = 1'b0;
  endtask

  function automatic logic [7:0] onecold(input int k);
    logic [7:0] v;
    v = 8'd1 << k;
    return ~v;
  endfunction

  logic [6:0] exp1 [8];

  initial begin
    checks = 0;
    errors = 0;
    // digit i of 32'h1234ABCD, digit 0 rightmost
    exp1[0] = 7'h21; exp1[1] = 7'h46; exp1[2] = 7'h03; exp1[3] = 7'h08;
    exp1[4] = 7'h19; exp1[5] = 7'h30; exp1[6] = 7'h24; exp1[7] = 7'h79;

    rst          = 1'b1;
    bus4.Data    = '0; bus4.Load = 1'b0; bus4.DigitEn = 8'hFF;
    bus4.BlankLZ = 1'b0; bus4.DpMask = '0;
    bus1.Data    = '0; bus1.Load = 1'b0; bus1.DigitEn = 8'hFF;
    bus1.BlankLZ = 1'b0; bus1.DpMask = '0;

    wait_edges(2);
    check("rst_en",  bus4.en_out,   8'hFF);
    check("rst_seg", bus4.out7,     7'h7F);
    check("rst_dp",  bus4.dp_out,   1'b1);
    check("rst_idx", bus4.DigitIdx, 3'd0);

    // Full scan of 1234ABCD, load captured on the first edge after release
    rst         = 1'b0;
    bus4.Data   = 32'h1234ABCD;
    bus4.Load   = 1'b1;
    wait_edges(1);
    bus4.Load   = 1'b0;
    wait_edges(2);
    check("dark_before_tick", bus4.en_out, 8'hFF);
    step_slot("scan1_d1", 1, 3'd1, 8'hFD, exp1[1], 1'b1);
    for (int s = 2; s <= 8; s++)
      step_slot("scan1", 4, 3'(s % 8), onecold(s % 8), exp1[s % 8], 1'b1);

    // Leading-zero blanking on 000000F0
    bus4.BlankLZ = 1'b1;
    load_word(32'h0000_00F0, 8'h00);
    step_slot("lz_d1", 3, 3'd1, 8'hFD, 7'h0E, 1'b1);
    for (int k = 2; k <= 7; k++)
      step_slot("lz_blank", 4, 3'(k), onecold(k), 7'h7F, 1'b1);
    step_slot("lz_d0", 4, 3'd0, 8'hFE, 7'h40, 1'b1);
    bus4.BlankLZ = 1'b0;
    step_slot("nolz_d1", 4, 3'd1, 8'hFD, 7'h0E, 1'b1);
    step_slot("nolz_d2", 4, 3'd2, 8'hFB, 7'h40, 1'b1);

    // All-zero value with blanking: only digit 0 shows 0
    bus4.BlankLZ = 1'b1;
    load_word(32'h0, 8'h00);
    for (int k = 3; k <= 7; k++)
      step_slot("zero_blank", (k == 3) ? 3 : 4, 3'(k), onecold(k), 7'h7F, 1'b1);
    step_slot("zero_d0", 4, 3'd0, 8'hFE, 7'h40, 1'b1);
    step_slot("zero_d1", 4, 3'd1, 8'hFD, 7'h7F, 1'b1);

    // Digit enables F0: slots 0..3 dark but still consumed
    bus4.DigitEn = 8'hF0;
    bus4.BlankLZ = 1'b0;
    step_slot("den_off2", 4, 3'd2, 8'hFF, 7'h7F, 1'b1);
    step_slot("den_off3", 4, 3'd3, 8'hFF, 7'h7F, 1'b1);
    for (int k = 4; k <= 7; k++)
      step_slot("den_on", 4, 3'(k), onecold(k), 7'h40, 1'b1);
    step_slot("den_off0", 4, 3'd0, 8'hFF, 7'h7F, 1'b1);
    step_slot("den_off1", 4, 3'd1, 8'hFF, 7'h7F, 1'b1);
    bus4.DigitEn = 8'hFF;

    // Load coinciding with a tick edge
    load_word(32'h1111_1111, 8'h01);
    step_slot("ld_pre", 3, 3'd2, 8'hFB, 7'h79, 1'b1);
    wait_edges(3);
    bus4.Data = 32'h2222_2222;
    bus4.Load = 1'b1;
    step_slot("ld_tick_old", 1, 3'd3, 8'hF7, 7'h79, 1'b1);
    bus4.Load = 1'b0;
    for (int k = 4; k <= 7; k++)
      step_slot("ld_new", 4, 3'(k), onecold(k), 7'h24, 1'b1);
    step_slot("dp_d0", 4, 3'd0, 8'hFE, 7'h24, 1'b0);
    for (int k = 1; k <= 5; k++)
      step_slot("dp_off", 4, 3'(k), onecold(k), 7'h24, 1'b1);

    // Reset mid-slot 5, asynchronous blanking then restart
    wait_edges(2);
    rst = 1'b1;
    #1;
    check("mid_rst_en",   bus4.en_out,   8'hFF);
    check("mid_rst_seg",  bus4.out7,     7'h7F);
    check("mid_rst_dp",   bus4.dp_out,   1'b1);
    check("mid_rst_idx",  bus4.DigitIdx, 3'd0);
    check("mid_rst_en1",  bus1.en_out,   8'hFF);
    wait_edges(1);
    rst = 1'b0;
    wait_edges(1);
    check("div1_idx1", bus1.DigitIdx, 3'd1);
    check("div1_en1",  bus1.en_out,   8'hFD);
    check("div1_seg1", bus1.out7,     7'h40);
    check("post_rst_dark1", bus4.en_out, 8'hFF);
    wait_edges(1);
    check("div1_idx2", bus1.DigitIdx, 3'd2);
    check("div1_en2",  bus1.en_out,   8'hFB);
    wait_edges(1);
    check("post_rst_dark3", bus4.en_out, 8'hFF);
    step_slot("post_rst_d1", 1, 3'd1, 8'hFD, 7'h40, 1'b1);
    check("div1_idx4", bus1.DigitIdx, 3'd4);
    check("div1_en4",  bus1.en_out,   8'hEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Parametrised time-multiplexed seven-segment display controller. Drives NUM_DIGITS common-anode digits from a hex word.
- Generalises the fixed two-by-four-digit display used on the board top, and adds:
  - an internal refresh prescaler;
  - a load-strobed shadow register;
  - per-digit enable mask;
  - leading-zero blanking;
  - decimal points.
- Sits between the CPU debug outputs (PC, write data) and the board segment/anode pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; legal range 1..16.
- REFRESH_DIV, 100000, Clk cycles each digit stays lit; legal range >= 1.

Ports:
- Clk  input  1  system clock; all state on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Data  input  4*NUM_DIGITS  hex value to display; nibble i drives digit i (digit 0 = rightmost).
- Load  input  1  when high on a Clk edge, Data and DpMask are captured into shadow registers.
- DigitEn  input  NUM_DIGITS  per-digit enable; 0 forces that digit dark.
- BlankLZ  input  1  1 = suppress leading zeros.
- DpMask  input  NUM_DIGITS  decimal point request per digit.
- out7  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp_out  output  1  decimal point, active-low, registered.
- en_out  output  NUM_DIGITS  digit anodes, active-low, one-cold, registered.
- DigitIdx  output  ceil(log2(NUM_DIGITS)), minimum 1  index of the currently lit digit slot.

Behaviour:
- Reset (async, active-high) clears:
  - prescaler, DigitIdx, shadow Data and shadow DpMask to 0;
  - en_out to all ones, out7 to 7'h7F, dp_out to 1.
- Prescaler counts 0..REFRESH_DIV-1 and wraps to 0. "tick" = prescaler at REFRESH_DIV-1.
- On tick:
  - DigitIdx advances by 1 and wraps from NUM_DIGITS-1 to 0.
  - en_out, out7 and dp_out are reloaded for the new index in the same edge.
- Between ticks, outputs hold their values.
- First lit digit after reset appears REFRESH_DIV cycles after Reset deasserts, showing digit 1 (the index advanced from 0 to 1). Digit 0 is next lit after the full wrap.
- REFRESH_DIV=1: tick every cycle; a digit changes every Clk.
- Shadow registers:
  - Load=1 captures Data and DpMask on that edge.
  - Display logic reads only the shadow registers, never Data directly.
- Load and tick on the same edge: the newly lit digit uses the pre-edge shadow contents. The new value first appears at the next tick.
- Decode, hex (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - blank=7F
- Leading-zero blanking, when BlankLZ=1:
  - digit i (i>0) is blank if shadow nibbles i..NUM_DIGITS-1 are all zero;
  - digit 0 is never blanked by this rule, so value 0 shows a single "0".
- Disabled digit (DigitEn[i]=0):
  - its slot is still consumed, keeping duty cycle uniform;
  - en_out stays all ones, out7=7F, dp_out=1 during that slot.
- Blanked digit (leading zero, but enabled):
  - en_out bit i is low, out7=7F;
  - dp_out still follows DpMask[i], so the decimal point remains visible.
- dp_out = ~shadowDp[idx] when the digit is enabled.
- DigitEn and BlankLZ are sampled live at each tick, not shadowed.
- Reset mid-scan: outputs go dark immediately (asynchronous) and the scan restarts from index 0.
- Exactly one en_out bit is low at any time after the first tick, unless the current digit is disabled.

Test Plan (NUM_DIGITS=8, REFRESH_DIV=4 unless noted):
- Reset then Load Data=32'h1234ABCD, DigitEn=FF, BlankLZ=0 -> after each 4 cycles en_out steps FD,FB,...,7F,FE. out7 on digit 0 = 21 (d), on digit 7 = 79 (1).
- Load 32'h0000_00F0, BlankLZ=1 -> digits 7..2 have out7=7F with anode low, digit 1=0E, digit 0=40. With BlankLZ=0, digits 7..2 show 40.
- Load 32'h0, BlankLZ=1 -> only digit 0 shows 40; all others 7F.
- DigitEn=8'hF0 -> en_out stays FF during slots 0..3 and cycles normally for slots 4..7. Each full scan takes 32 cycles.
- Load asserted on the tick edge with Data changing 1111_1111 -> 2222_2222 -> lit digit shows 79 for that slot and 24 from the next tick onward. DpMask=01 gives dp_out=0 only on slot 0.
- Assert Reset mid-slot 5 -> en_out=FF and out7=7F immediately. After release, digit 1 is the first lit digit, 4 cycles later. With REFRESH_DIV=1, the index advances every cycle.
